// File: rtl/dca_matrix_load_sequencer.sv
// dca_matrix_load_sequencer
// Splits one matrix-load instruction into one AXI read burst per row.
// For each issued burst the formatter info (txn_*) is reported, registered,
// in the cycle after the AR handshake. Outstanding bursts are counted on AR
// handshakes and retired on R beats carrying rlast.
module dca_matrix_load_sequencer #(
    parameter int BW_ADDR         = 32,
    parameter int BW_AXI_DATA     = 128,
    parameter int BW_ELEMENT      = 32,
    parameter int MATRIX_NUM_COL  = 4,
    parameter int BW_NUM_ROW      = 8,
    parameter int BW_STRIDE       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              inst_valid,
    output logic                              inst_ready,
    input  logic [BW_ADDR-1:0]                inst_addr,
    input  logic [BW_STRIDE-1:0]              inst_stride_ls3,
    input  logic [BW_NUM_ROW-1:0]             inst_num_row_m1,
    input  logic [$clog2(MATRIX_NUM_COL)-1:0] inst_num_col_m1,
    output logic                              axi_arvalid,
    input  logic                              axi_arready,
    output logic [BW_ADDR-1:0]                axi_araddr,
    output logic [7:0]                        axi_arlen,
    input  logic                              axi_rvalid,
    input  logic                              axi_rready,
    input  logic                              axi_rlast,
    output logic                              txn_valid,
    output logic [$clog2(BW_AXI_DATA)-1:0]    txn_bitaddr,
    output logic [7:0]                        txn_alen,
    output logic                              txn_is_first_row,
    output logic                              txn_is_last_row,
    output logic [MATRIX_NUM_COL-1:0]         txn_col_mask,
    output logic                              busy,
    output logic                              done
);

    localparam int BPB    = BW_AXI_DATA / 8;
    localparam int BW_OFF = $clog2(BPB);
    localparam int BW_BIT = $clog2(BW_AXI_DATA);
    localparam int BW_COL = $clog2(MATRIX_NUM_COL);
    localparam int BW_OUT = $clog2(MAX_OUTSTANDING) + 1;

    localparam logic [BW_OUT-1:0]     OUT_ZERO = {BW_OUT{1'b0}};
    localparam logic [BW_OUT-1:0]     OUT_ONE  = BW_OUT'(1);
    localparam logic [BW_OUT-1:0]     OUT_MAX  = BW_OUT'(MAX_OUTSTANDING);
    localparam logic [BW_NUM_ROW-1:0] ROW_ZERO = {BW_NUM_ROW{1'b0}};
    localparam logic [BW_NUM_ROW-1:0] ROW_ONE  = BW_NUM_ROW'(1);
    localparam logic [BW_ADDR-1:0]    OFF_MASK = BW_ADDR'(BPB - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Start of the row's first beat.
    function automatic logic [BW_ADDR-1:0] beat_align(input logic [BW_ADDR-1:0] addr);
        beat_align = addr & ~OFF_MASK;
    endfunction

    // Beats minus one needed to cover the row starting at byte offset off.
    function automatic logic [7:0] burst_len(input logic [BW_OFF-1:0] off,
                                             input logic [BW_COL-1:0] ncol_m1);
        logic [31:0] row_bytes;
        logic [31:0] span;
        row_bytes = (32'(ncol_m1) + 32'd1) * 32'(BW_ELEMENT / 8);
        span      = 32'(off) + row_bytes - 32'd1;
        burst_len = 8'(span >> BW_OFF);
    endfunction

    // Bit position of the row inside the first beat.
    function automatic logic [BW_BIT-1:0] bit_offset(input logic [BW_OFF-1:0] off);
        bit_offset = {off, 3'b000};
    endfunction

    // Columns 0..ncol_m1 are valid.
    function automatic logic [MATRIX_NUM_COL-1:0] col_mask(input logic [BW_COL-1:0] ncol_m1);
        col_mask = {MATRIX_NUM_COL{1'b0}};
        for (int i = 0; i < MATRIX_NUM_COL; i++) begin
            col_mask[i] = (32'(i) <= 32'(ncol_m1));
        end
    endfunction

    state_t                  state_r, state_next_s;
    logic [BW_ADDR-1:0]      addr_r, addr_next_s, stride_bytes_s;
    logic [BW_STRIDE-1:0]    stride_r;
    logic [BW_NUM_ROW-1:0]   num_row_m1_r, num_row_next_s;
    logic [BW_COL-1:0]       num_col_m1_r, num_col_next_s;
    logic [BW_NUM_ROW-1:0]   row_cnt_r, row_cnt_next_s;
    logic [BW_OUT-1:0]       out_cnt_r, out_next_s;
    logic                    accept_s, ar_hs_s, retire_s, hold_ar_s, load_ar_s;

    logic                    arvalid_r;
    logic [BW_ADDR-1:0]      araddr_r;
    logic [7:0]              arlen_r;
    logic [BW_BIT-1:0]       ar_bitaddr_r;
    logic                    ar_first_r, ar_last_r;
    logic                    txn_valid_r;
    logic [BW_BIT-1:0]       txn_bitaddr_r;
    logic [7:0]              txn_alen_r;
    logic                    txn_first_r, txn_last_r;
    logic [MATRIX_NUM_COL-1:0] col_mask_r;
    logic                    inst_ready_r, busy_r, done_r;

    // Handshake decode; retires with nothing outstanding are dropped.
    always_comb begin
        accept_s       = inst_valid & inst_ready_r;
        ar_hs_s        = arvalid_r & axi_arready;
        retire_s       = axi_rvalid & axi_rready & axi_rlast & (out_cnt_r != OUT_ZERO);
        hold_ar_s      = arvalid_r & ~axi_arready;
        stride_bytes_s = BW_ADDR'({stride_r, 3'b000});
    end

    // Next values of the instruction-scoped counters and row pointer.
    always_comb begin
        out_next_s     = out_cnt_r;
        addr_next_s    = addr_r;
        row_cnt_next_s = row_cnt_r;
        num_row_next_s = num_row_m1_r;
        num_col_next_s = num_col_m1_r;
        if (accept_s) begin
            out_next_s     = OUT_ZERO;
            addr_next_s    = inst_addr;
            row_cnt_next_s = ROW_ZERO;
            num_row_next_s = inst_num_row_m1;
            num_col_next_s = inst_num_col_m1;
        end else begin
            if (ar_hs_s && !retire_s) begin
                out_next_s = out_cnt_r + OUT_ONE;
            end else if (!ar_hs_s && retire_s) begin
                out_next_s = out_cnt_r - OUT_ONE;
            end else begin
                out_next_s = out_cnt_r;
            end
            if (ar_hs_s) begin
                addr_next_s    = addr_r + stride_bytes_s;
                row_cnt_next_s = row_cnt_r + ROW_ONE;
            end else begin
                addr_next_s    = addr_r;
                row_cnt_next_s = row_cnt_r;
            end
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_next_s = ST_ISSUE;
                else          state_next_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (ar_hs_s && (row_cnt_r == num_row_m1_r)) state_next_s = ST_DRAIN;
                else                                        state_next_s = ST_ISSUE;
            end
            ST_DRAIN: begin
                if (out_next_s == OUT_ZERO) state_next_s = ST_DONE;
                else                        state_next_s = ST_DRAIN;
            end
            ST_DONE:  state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Present a new row whenever the slot is free and the outstanding limit allows.
    always_comb begin
        load_ar_s = (state_next_s == ST_ISSUE) && !hold_ar_s && (out_next_s < OUT_MAX);
    end

    // State, counters, latched instruction and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            out_cnt_r    <= OUT_ZERO;
            addr_r       <= {BW_ADDR{1'b0}};
            row_cnt_r    <= ROW_ZERO;
            num_row_m1_r <= ROW_ZERO;
            num_col_m1_r <= {BW_COL{1'b0}};
            stride_r     <= {BW_STRIDE{1'b0}};
            inst_ready_r <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            out_cnt_r    <= out_next_s;
            addr_r       <= addr_next_s;
            row_cnt_r    <= row_cnt_next_s;
            num_row_m1_r <= num_row_next_s;
            num_col_m1_r <= num_col_next_s;
            if (accept_s) begin
                stride_r <= inst_stride_ls3;
            end
            inst_ready_r <= (state_next_s == ST_IDLE);
            busy_r       <= (state_next_s != ST_IDLE);
            done_r       <= (state_next_s == ST_DONE);
        end
    end

    // AR channel registers; held stable while the slave stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arvalid_r    <= 1'b0;
            araddr_r     <= {BW_ADDR{1'b0}};
            arlen_r      <= 8'd0;
            ar_bitaddr_r <= {BW_BIT{1'b0}};
            ar_first_r   <= 1'b0;
            ar_last_r    <= 1'b0;
        end else if (hold_ar_s) begin
            arvalid_r <= 1'b1;
        end else if (load_ar_s) begin
            arvalid_r    <= 1'b1;
            araddr_r     <= beat_align(addr_next_s);
            arlen_r      <= burst_len(addr_next_s[BW_OFF-1:0], num_col_next_s);
            ar_bitaddr_r <= bit_offset(addr_next_s[BW_OFF-1:0]);
            ar_first_r   <= (row_cnt_next_s == ROW_ZERO);
            ar_last_r    <= (row_cnt_next_s == num_row_next_s);
        end else begin
            arvalid_r <= 1'b0;
        end
    end

    // Per-transaction report captured from the burst that just handshook.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_valid_r   <= 1'b0;
            txn_bitaddr_r <= {BW_BIT{1'b0}};
            txn_alen_r    <= 8'd0;
            txn_first_r   <= 1'b0;
            txn_last_r    <= 1'b0;
            col_mask_r    <= {MATRIX_NUM_COL{1'b0}};
        end else begin
            txn_valid_r <= ar_hs_s;
            if (ar_hs_s) begin
                txn_bitaddr_r <= ar_bitaddr_r;
                txn_alen_r    <= arlen_r;
                txn_first_r   <= ar_first_r;
                txn_last_r    <= ar_last_r;
            end
            if (accept_s) begin
                col_mask_r <= col_mask(inst_num_col_m1);
            end
        end
    end

    assign inst_ready       = inst_ready_r;
    assign axi_arvalid      = arvalid_r;
    assign axi_araddr       = araddr_r;
    assign axi_arlen        = arlen_r;
    assign txn_valid        = txn_valid_r;
    assign txn_bitaddr      = txn_bitaddr_r;
    assign txn_alen         = txn_alen_r;
    assign txn_is_first_row = txn_first_r;
    assign txn_is_last_row  = txn_last_r;
    assign txn_col_mask     = col_mask_r;
    assign busy             = busy_r;
    assign done             = done_r;

endmodule

// File: tb/tb_dca_matrix_load_sequencer.sv
// Testbench for dca_matrix_load_sequencer: random AR/R handshakes checked
// cycle by cycle against a row-list and outstanding-count reference model.
module tb_dca_matrix_load_sequencer;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_addr;
    logic [15:0] inst_stride_ls3;
    logic [7:0]  inst_num_row_m1;
    logic [1:0]  inst_num_col_m1;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic        axi_rvalid;
    logic        axi_rready;
    logic        axi_rlast;
    logic        txn_valid;
    logic [6:0]  txn_bitaddr;
    logic [7:0]  txn_alen;
    logic        txn_is_first_row;
    logic        txn_is_last_row;
    logic [3:0]  txn_col_mask;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dca_matrix_load_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst_addr        (inst_addr),
        .inst_stride_ls3  (inst_stride_ls3),
        .inst_num_row_m1  (inst_num_row_m1),
        .inst_num_col_m1  (inst_num_col_m1),
        .axi_arvalid      (axi_arvalid),
        .axi_arready      (axi_arready),
        .axi_araddr       (axi_araddr),
        .axi_arlen        (axi_arlen),
        .axi_rvalid       (axi_rvalid),
        .axi_rready       (axi_rready),
        .axi_rlast        (axi_rlast),
        .txn_valid        (txn_valid),
        .txn_bitaddr      (txn_bitaddr),
        .txn_alen         (txn_alen),
        .txn_is_first_row (txn_is_first_row),
        .txn_is_last_row  (txn_is_last_row),
        .txn_col_mask     (txn_col_mask),
        .busy             (busy),
        .done             (done)
    );

    // Runs one instruction; abort_after >= 0 stops once that many rows issued.
    task automatic run_inst(input string name, input logic [31:0] addr, input logic [15:0] stride,
                            input logic [7:0] nrow_m1, input logic [1:0] ncol_m1,
                            input int ar_pct, input int r_pct, input int ar_hold,
                            input int r_hold, input int abort_after);
        logic [31:0] e_addr[$];
        logic [7:0]  e_len[$];
        logic [6:0]  e_bit[$];
        logic [31:0] a;
        logic [3:0]  e_mask;
        int nrows, rb, off, issued, outst, pidx, cyc;
        bit drain, pend, fin, stop, hs, ret, e_arv;
        nrows = int'(nrow_m1) + 1;
        rb    = (int'(ncol_m1) + 1) * 4;
        for (int r = 0; r < nrows; r++) begin
            a   = addr + 32'(r) * 32'(stride) * 32'd8;
            off = int'(a % 32'd16);
            e_addr.push_back(a - 32'(off));
            e_len.push_back(8'((off + rb + 15) / 16 - 1));
            e_bit.push_back(7'(off * 8));
        end
        for (int i = 0; i < 4; i++) e_mask[i] = (i <= int'(ncol_m1));

        @(negedge clk);
        n_checks++;
        if (inst_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s inst_ready_idle: got %0b expected 1", name, inst_ready);
        end
        inst_valid = 1'b1; inst_addr = addr; inst_stride_ls3 = stride;
        inst_num_row_m1 = nrow_m1; inst_num_col_m1 = ncol_m1;
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rready = 1'b0; axi_rlast = 1'b0;
        @(negedge clk);
        inst_valid = 1'b0; inst_addr = $urandom; inst_stride_ls3 = 16'($urandom);
        inst_num_row_m1 = 8'($urandom); inst_num_col_m1 = 2'($urandom);

        issued = 0; outst = 0; pidx = 0; cyc = 0;
        drain = 1'b0; pend = 1'b0; fin = 1'b0; stop = 1'b0;
        while (!fin && !stop && cyc < 3000) begin
            e_arv = (issued < nrows) && (outst < MAXO);
            n_checks++;
            if (axi_arvalid !== e_arv) begin
                n_fail++;
                $display("FAIL %s arvalid cyc %0d: got %0b expected %0b (issued %0d outst %0d)",
                         name, cyc, axi_arvalid, e_arv, issued, outst);
            end
            if (e_arv) begin
                n_checks++;
                if (axi_araddr !== e_addr[issued] || axi_arlen !== e_len[issued]) begin
                    n_fail++;
                    $display("FAIL %s ar_fields row %0d: got addr %h len %0d expected addr %h len %0d",
                             name, issued, axi_araddr, axi_arlen, e_addr[issued], e_len[issued]);
                end
            end
            n_checks++;
            if (txn_valid !== pend) begin
                n_fail++;
                $display("FAIL %s txn_valid cyc %0d: got %0b expected %0b", name, cyc, txn_valid, pend);
            end
            if (pend) begin
                n_checks++;
                if ({txn_bitaddr, txn_alen, txn_is_first_row, txn_is_last_row} !==
                    {e_bit[pidx], e_len[pidx], pidx == 0, pidx == nrows - 1}) begin
                    n_fail++;
                    $display("FAIL %s txn_fields row %0d: got bit %0d len %0d f %0b l %0b expected bit %0d len %0d f %0b l %0b",
                             name, pidx, txn_bitaddr, txn_alen, txn_is_first_row, txn_is_last_row,
                             e_bit[pidx], e_len[pidx], pidx == 0, pidx == nrows - 1);
                end
            end
            n_checks++;
            if ({txn_col_mask, done, busy, inst_ready} !== {e_mask, 3'b010}) begin
                n_fail++;
                $display("FAIL %s status cyc %0d: got mask %b done %0b busy %0b ready %0b expected mask %b done 0 busy 1 ready 0",
                         name, cyc, txn_col_mask, done, busy, inst_ready, e_mask);
            end
            if (abort_after >= 0 && issued == abort_after) begin
                stop = 1'b1;
            end else begin
                axi_arready = (cyc >= ar_hold) && ($urandom_range(99) < ar_pct);
                axi_rvalid  = (cyc >= r_hold) && ($urandom_range(99) < r_pct);
                axi_rready  = ($urandom_range(99) < 85);
                axi_rlast   = ($urandom_range(99) < 60);
                hs   = axi_arvalid && axi_arready;
                ret  = axi_rvalid && axi_rready && axi_rlast && (outst > 0);
                pend = hs;
                pidx = issued;
                outst  = outst + int'(hs) - int'(ret);
                issued = issued + int'(hs);
                if (drain && outst == 0) fin = 1'b1;
                if (hs && issued == nrows) drain = 1'b1;
                @(negedge clk);
                cyc++;
            end
        end

        if (fin) begin
            n_checks++;
            if ({done, busy, inst_ready, axi_arvalid, txn_valid} !== 5'b11000) begin
                n_fail++;
                $display("FAIL %s done_cycle: got done %0b busy %0b ready %0b arvalid %0b txn %0b expected 1 1 0 0 0",
                         name, done, busy, inst_ready, axi_arvalid, txn_valid);
            end
            axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rready = 1'b0; axi_rlast = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({done, busy, inst_ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL %s after_done: got done %0b busy %0b ready %0b expected 0 0 1",
                         name, done, busy, inst_ready);
            end
        end else if (!stop) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got no done after %0d cycles, required done", name, cyc);
        end
    endtask

    task automatic test_reset();
        logic [65:0] got_v;
        logic [65:0] exp_v;
        rst = 1'b1; inst_valid = 1'b0; inst_addr = 32'd0; inst_stride_ls3 = 16'd0;
        inst_num_row_m1 = 8'd0; inst_num_col_m1 = 2'd0;
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rready = 1'b0; axi_rlast = 1'b0;
        repeat (3) @(negedge clk);
        exp_v = {1'b1, 1'b0, 32'd0, 8'd0, 1'b0, 7'd0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        got_v = {inst_ready, axi_arvalid, axi_araddr, axi_arlen, txn_valid, txn_bitaddr, txn_alen,
                 txn_is_first_row, txn_is_last_row, txn_col_mask, busy, done};
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", got_v, exp_v);
        end
        rst = 1'b0;
    endtask

    task automatic test_aligned_single();
        run_inst("aligned_single", 32'h0000_1000, 16'd0, 8'd0, 2'd3, 100, 100, 0, 0, -1);
    endtask

    task automatic test_misaligned();
        run_inst("misaligned", 32'h0000_1008, 16'd0, 8'd0, 2'd3, 100, 100, 0, 0, -1);
    endtask

    task automatic test_four_rows();
        run_inst("four_rows", 32'h0000_2000, 16'd4, 8'd3, 2'd3, 100, 100, 0, 0, -1);
    endtask

    task automatic test_outstanding_limit();
        run_inst("outstanding_limit", 32'h0000_3000, 16'd2, 8'd7, 2'd1, 100, 50, 0, 20, -1);
    endtask

    task automatic test_back_to_back();
        run_inst("back_to_back", 32'h0000_4004, 16'd3, 8'd9, 2'd2, 100, 100, 0, 0, -1);
    endtask

    task automatic test_ar_backpressure();
        run_inst("ar_backpressure", 32'h0000_5010, 16'd1, 8'd2, 2'd3, 100, 100, 5, 0, -1);
    endtask

    task automatic test_reset_mid();
        logic [65:0] got_v;
        logic [65:0] exp_v;
        run_inst("reset_mid", 32'h0000_6000, 16'd8, 8'd3, 2'd3, 100, 0, 0, 100, 2);
        #2 rst = 1'b1;
        #1;
        exp_v = {1'b1, 1'b0, 32'd0, 8'd0, 1'b0, 7'd0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        got_v = {inst_ready, axi_arvalid, axi_araddr, axi_arlen, txn_valid, txn_bitaddr, txn_alen,
                 txn_is_first_row, txn_is_last_row, txn_col_mask, busy, done};
        n_checks++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", got_v, exp_v);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            axi_rvalid = 1'b1; axi_rready = 1'b1; axi_rlast = 1'b1; axi_arready = 1'b1;
            @(negedge clk);
            n_checks++;
            if ({done, busy, inst_ready, axi_arvalid} !== 4'b0010) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got done %0b busy %0b ready %0b arvalid %0b expected 0 0 1 0",
                         i, done, busy, inst_ready, axi_arvalid);
            end
        end
        axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_arready = 1'b0;
        run_inst("after_reset", 32'h0000_7004, 16'd5, 8'd3, 2'd0, 80, 70, 0, 0, -1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            run_inst("random", $urandom & 32'hFFFF_FFFC, 16'($urandom_range(0, 65535)),
                     8'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                     int'($urandom_range(30, 100)), int'($urandom_range(40, 100)), 0, 0, -1);
        end
        run_inst("addr_wrap", 32'hFFFF_FFF4, 16'd2, 8'd3, 2'd3, 70, 80, 0, 0, -1);
    endtask

    initial begin
        test_reset();
        test_aligned_single();
        test_misaligned();
        test_four_rows();
        test_outstanding_limit();
        test_back_to_back();
        test_ar_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dca_matrix_load_sequencer.md
# dca_matrix_load_sequencer

Sequences one matrix-load instruction into per-row AXI read bursts for the DCA matrix LSU. For every read burst it issues, it produces the per-transaction information (bit offset, burst length, row flags) and the column-valid mask. The downstream read-response formatter consumes these to turn AXI beats into tensor rows. It sits between the LSU instruction decoder and the AXI AR channel, and tracks outstanding bursts through the R channel.

## Interface
Parameters:
- BW_ADDR, 32: AXI address width.
- BW_AXI_DATA, 128: AXI data width in bits. Bytes per beat is BPB = BW_AXI_DATA/8.
- BW_ELEMENT, 32: element width in bits. Must be a multiple of 8.
- MATRIX_NUM_COL, 4: maximum columns per row.
- BW_NUM_ROW, 8: width of num_row_m1.
- BW_STRIDE, 16: width of stride_ls3.
- MAX_OUTSTANDING, 4: maximum AR bursts in flight. Power of 2, at least 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst_valid  in  1  instruction request.
- inst_ready  out  1  high only in IDLE.
- inst_addr  in  BW_ADDR  byte address of row 0. Element-aligned.
- inst_stride_ls3  in  BW_STRIDE  row pitch in 8-byte units.
- inst_num_row_m1  in  BW_NUM_ROW  number of rows minus 1.
- inst_num_col_m1  in  clog2(MATRIX_NUM_COL)  number of columns minus 1.
- axi_arvalid  out  1  read address valid.
- axi_arready  in  1  read address ready.
- axi_araddr  out  BW_ADDR  beat-aligned burst address.
- axi_arlen  out  8  beats minus 1.
- axi_rvalid, axi_rready, axi_rlast  in  1 each  monitored R handshake.
- txn_valid  out  1  one-cycle pulse on each AR handshake.
- txn_bitaddr  out  clog2(BW_AXI_DATA)  bit offset of the row inside the first beat.
- txn_alen  out  8  copy of the issued arlen.
- txn_is_first_row, txn_is_last_row  out  1 each  row flags.
- txn_col_mask  out  MATRIX_NUM_COL  bit i set iff i ≤ num_col_m1.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the last burst retires.

## Operation
- States:
  - IDLE: waiting for an instruction.
  - ISSUE: issuing row bursts.
  - DRAIN: all rows issued; waiting for outstanding bursts to retire.
  - DONE: one cycle; asserts done.
- IDLE→ISSUE on inst_valid&inst_ready. The cycle of that handshake latches all instruction fields and clears row_cnt and the outstanding count.
- Per-row arithmetic for row address A:
  - row_bytes = (num_col_m1+1)*BW_ELEMENT/8
  - off = A mod BPB
  - axi_araddr = A − off
  - axi_arlen = ceil((off+row_bytes)/BPB) − 1
  - txn_bitaddr = off*8
- Next row address: A + (stride_ls3<<3), modulo 2^BW_ADDR. Address wrap-around is silent.
- In ISSUE, axi_arvalid is asserted when outstanding < MAX_OUTSTANDING.
- Once asserted, axi_arvalid and all AR/txn fields stay stable until axi_arready.
- On an AR handshake:
  - txn_valid pulses with that row's fields.
  - row_cnt increments and the outstanding count increments.
  - If row_cnt == num_row_m1, the next state is DRAIN.
- Retire: axi_rvalid&axi_rready&axi_rlast decrements the outstanding count.
- Issue and retire in the same cycle leave the count unchanged.
- A retire while the count is 0 is ignored; the count saturates at 0.
- DRAIN→DONE when the count is 0, or reaches 0 through a retire this cycle. DONE→IDLE unconditionally.
- txn_is_first_row = (row_cnt==0). txn_is_last_row = (row_cnt==num_row_m1). Both are set together when num_row_m1 = 0.
- txn_col_mask is constant for the whole instruction.

## Timing
- Reset values:
  - state IDLE
  - inst_ready=1
  - axi_arvalid=0, axi_araddr=0, axi_arlen=0
  - txn_valid=0, txn_bitaddr=0, txn_alen=0
  - txn_is_first_row=0, txn_is_last_row=0, txn_col_mask=0
  - busy=0, done=0
- The first axi_arvalid rises 1 cycle after the instruction handshake.
- With axi_arready held at 1 and no back-pressure from the outstanding limit, one burst issues per cycle.
- inst_ready is 0 from the cycle after the accept through the DONE cycle. It returns to 1 in the cycle after done.
- done is asserted for exactly one cycle, while the state is DONE.
- All outputs are registered. No combinational path from axi_arready to axi_arvalid.
- rst asserted mid-operation: immediate return to reset values. The in-flight AR is abandoned; R beats arriving afterwards are ignored.

## Test plan
- Aligned single row:
  - Stimulus: addr 0x1000, num_row_m1 0, num_col_m1 3, arready=1.
  - Expected: one AR with araddr 0x1000, arlen 0; txn bitaddr 0, first=last=1, mask 4'b1111; done one cycle after rlast.
- Misaligned row:
  - Stimulus: addr 0x1008, num_col_m1 3.
  - Expected: araddr 0x1000, arlen 1, bitaddr 64.
- Four rows:
  - Stimulus: addr 0x2000, stride_ls3 4, num_row_m1 3.
  - Expected: araddr 0x2000, 0x2020, 0x2040, 0x2060; first only on row 0; last only on row 3.
- Outstanding limit:
  - Stimulus: num_row_m1 7, no rlast.
  - Expected: exactly 4 ARs, then arvalid low. Each subsequent rlast releases one more AR. Same-cycle issue and retire keeps the count unchanged.
- AR back-pressure:
  - Stimulus: arready held low for 5 cycles.
  - Expected: arvalid, araddr and arlen stable for all 5 cycles; txn_valid pulses only on the handshake cycle.
- Reset mid-operation:
  - Stimulus: rst asserted after 2 of 4 rows are issued.
  - Expected: all outputs return to reset values asynchronously; no done pulse; a new instruction is accepted normally afterwards.
